// File: rtl/mac_dot_sequencer_if.sv
// Bundles the command, scratchpad-read and MAC connections of the dot-product sequencer.
// The sequencer takes the slave modport; the surrounding command/memory/MAC logic takes master.
interface mac_dot_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
);
    logic              io_start;
    logic [ADDR_W-1:0] io_base;
    logic [LEN_W-1:0]  io_len;
    logic [15:0]       io_init;
    logic              io_busy;
    logic              io_rd_en;
    logic [ADDR_W-1:0] io_rd_addr;
    logic [15:0]       io_rd_a;
    logic [15:0]       io_rd_b;
    logic [15:0]       io_mac_a;
    logic [15:0]       io_mac_b;
    logic [15:0]       io_mac_c;
    logic [15:0]       io_mac_out;
    logic              io_done;
    logic [15:0]       io_result;

    modport master (
        output io_start, io_base, io_len, io_init,
        output io_rd_a, io_rd_b, io_mac_out,
        input  io_busy, io_rd_en, io_rd_addr,
        input  io_mac_a, io_mac_b, io_mac_c,
        input  io_done, io_result
    );

    modport slave (
        input  io_start, io_base, io_len, io_init,
        input  io_rd_a, io_rd_b, io_mac_out,
        output io_busy, io_rd_en, io_rd_addr,
        output io_mac_a, io_mac_b, io_mac_c,
        output io_done, io_result
    );
endinterface

// File: rtl/mac_dot_sequencer.sv
// Streams two operand vectors from a synchronous-read scratchpad through an external
// combinational MAC, feeding the MAC output back as the addend, and returns the sum.
module mac_dot_sequencer #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    mac_dot_sequencer_if.slave   bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]        state_reg;
    logic [1:0]        state_next;
    logic [ADDR_W-1:0] base_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  k_reg;
    logic [15:0]       acc_reg;
    logic [15:0]       acc_next;
    logic [15:0]       result_reg;
    logic              valid_reg;
    logic              last_issue;
    logic              rd_en;

    assign rd_en      = (state_reg == ST_RUN);
    assign last_issue = (k_reg == (len_reg - LEN_W'(1)));

    // The MAC output only becomes the new accumulator while read data is valid.
    assign acc_next = valid_reg ? bus.io_mac_out : acc_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.io_start) begin
                    state_next = (bus.io_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_issue) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: state_next = ST_DONE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            base_reg   <= '0;
            len_reg    <= '0;
            k_reg      <= '0;
            acc_reg    <= '0;
            result_reg <= '0;
            valid_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            valid_reg <= rd_en;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.io_start) begin
                        base_reg <= bus.io_base;
                        len_reg  <= bus.io_len;
                        k_reg    <= '0;
                        acc_reg  <= bus.io_init;
                        // Zero-length runs go straight to DONE with the initial value.
                        if (bus.io_len == '0) begin
                            result_reg <= bus.io_init;
                        end
                    end
                end
                ST_RUN: begin
                    k_reg   <= k_reg + LEN_W'(1);
                    acc_reg <= acc_next;
                end
                ST_DRAIN: begin
                    acc_reg    <= acc_next;
                    result_reg <= acc_next;
                end
                default: ;
            endcase
        end
    end

    // Operands are forced to zero whenever no read data is in flight.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_operand_gate
            assign bus.io_mac_a[gi] = bus.io_rd_a[gi] & valid_reg;
            assign bus.io_mac_b[gi] = bus.io_rd_b[gi] & valid_reg;
        end
    endgenerate

    assign bus.io_mac_c   = acc_reg;
    assign bus.io_busy    = (state_reg != ST_IDLE);
    assign bus.io_rd_en   = rd_en;
    assign bus.io_rd_addr = rd_en ? (base_reg + ADDR_W'(k_reg)) : '0;
    assign bus.io_done    = (state_reg == ST_DONE);
    assign bus.io_result  = result_reg;

endmodule

// File: doc/mac_dot_sequencer.md
# mac_dot_sequencer

Initiator-side controller for the FP16MAC datapath: streams two operand vectors from a synchronous-read scratchpad into an external combinational MAC (out = a*b + c, truncated to 16 bits), feeds the MAC output back as the next addend, and returns the final accumulated value. It sits between the PIM command logic, which issues start/length/base, and the MAC instance, turning the single-shot MAC into an N-element dot-product engine.

## Interface

Parameters:
- ADDR_W, 8, scratchpad address width; addresses wrap modulo 2^ADDR_W
- LEN_W, 8, width of element count; max vector length 2^LEN_W − 1

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- io_start  in  1  launch request, sampled only in IDLE
- io_base  in  ADDR_W  first element address, sampled with io_start
- io_len  in  LEN_W  element count, sampled with io_start
- io_init  in  16  initial accumulator value, sampled with io_start
- io_busy  out  1  high whenever state ≠ IDLE
- io_rd_en  out  1  scratchpad read strobe
- io_rd_addr  out  ADDR_W  scratchpad read address
- io_rd_a  in  16  operand A data, valid the cycle after io_rd_en
- io_rd_b  in  16  operand B data, valid the cycle after io_rd_en
- io_mac_a  out  16  to MAC a
- io_mac_b  out  16  to MAC b
- io_mac_c  out  16  to MAC c (current accumulator)
- io_mac_out  in  16  from MAC out
- io_done  out  1  one-cycle pulse when io_result updates
- io_result  out  16  final accumulator, held until next io_done

## Operation

- States: IDLE, RUN, DRAIN, DONE.
- IDLE: io_start=1 → latch base, len, acc ← io_init, issue counter k ← 0; go RUN if len>0, else DONE.
- RUN: io_rd_en=1, io_rd_addr = (base + k) mod 2^ADDR_W; k increments each cycle; after issuing k = len−1 go DRAIN.
- Read pipeline: internal valid flag = io_rd_en delayed one cycle. When flag=1: io_mac_a=io_rd_a, io_mac_b=io_rd_b, acc ← io_mac_out at the clock edge. When flag=0: io_mac_a=io_mac_b=0, acc unchanged.
- io_mac_c = acc at all times.
- DRAIN: one cycle consuming the last read's data; go DONE.
- DONE: io_result ← acc (registered on DONE entry, visible in DONE), io_done=1 for exactly that cycle; go IDLE.
- Arithmetic: all 16-bit, wrap-around; no saturation, no overflow flag (matches MAC truncation).
- io_start while busy: ignored, no queueing. io_start in DONE cycle: ignored.
- Input changes on io_base/io_len/io_init after launch have no effect.

## Timing

- Start sampled in cycle 0 (IDLE, io_start=1).
- io_rd_en high cycles 1..len, addresses base..base+len−1.
- MAC operands valid cycles 2..len+1; acc updated at end of each.
- io_done high in cycle len+2; IDLE in cycle len+3; earliest next start sampled in cycle len+3.
- io_busy high cycles 1..len+2.
- len=0: DONE in cycle 1, io_result=io_init, no reads issued.
- Throughput: one element per cycle; total occupancy len+3 cycles start-to-start.
- Reset (any time, including mid-RUN): state IDLE, acc=0, k=0, valid flag=0, io_busy=0, io_rd_en=0, io_rd_addr=0, io_mac_a/b/c=0, io_done=0, io_result=0. Aborted operation produces no io_done; start after reset deasserts behaves normally.

## Test plan

- Basic dot product: base=0x10, len=3, init=0, A=[1,2,3], B=[4,5,6] → rd_en cycles 1–3 at 0x10–0x12, io_done in cycle 5, io_result=0x0020, io_busy low cycle 6.
- Init and wrap: len=1, init=5, A=[0x0100], B=[0x0100] → product 0x10000 truncates to 0, io_result=0x0005; second run A=[0xFFFF], B=[1], init=1 → io_result=0x0000.
- Zero length: len=0, init=0x1234 → io_done in cycle 1, io_result=0x1234, io_rd_en never asserted.
- Address wrap and start-while-busy: base=0xFE, len=4 → addresses 0xFE,0xFF,0x00,0x01; io_start pulsed in cycle 2 with different len is ignored, exactly one io_done in cycle 6.
- Reset mid-run: len=8, assert reset in cycle 4 → all outputs 0 immediately, no io_done; new start len=2, A=[3,3], B=[3,3], init=0 → io_result=0x0012 in cycle 4 of the new run.
- Back-to-back: second start in cycle len+3 of first run → runs independently, io_result holds first value until second io_done.
